inbuf_fifo: RTL and testbench
=============================

# inbuf_fifo

Input-buffer FIFO serving the read interface driven by the input-buffer controller (`cntl_inbuf_fifo_rd_rq`, `cntl_inbuf_fifo_mem_en`, `inbuf_fifo_cntl_empty`). The host side writes data-packet words. The controller side pops them one per request, with 1-cycle registered read latency. The block holds the SRAM-style storage array, pointers, occupancy count, status flags and sticky error flags, and sits between the host/DMA loader and the control/engine datapath.

## Interface
- `DATA_W`, 32: word width.
- `DEPTH`, 16: number of entries; power of two, ≥ 2.
- `ADDR_W`, `$clog2(DEPTH)`: pointer width.
- `AFULL_TH`, `DEPTH-2`: almost-full threshold; flag asserts when count ≥ `AFULL_TH`.

Clock and reset: one clock; reset is asynchronous and active-high.

- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous clear of pointers, count and valid; driven by the engine soft reset.
- `host_inbuf_fifo_wr_rq`  in  1  write request.
- `host_inbuf_fifo_wr_data`  in  DATA_W  write data.
- `inbuf_fifo_host_full`  out  1  full flag.
- `inbuf_fifo_host_afull`  out  1  almost-full flag.
- `cntl_inbuf_fifo_rd_rq`  in  1  read (pop) request.
- `cntl_inbuf_fifo_mem_en`  in  1  read-port enable; when 0, the read port is idle.
- `inbuf_fifo_cntl_empty`  out  1  empty flag.
- `inbuf_fifo_rd_data`  out  DATA_W  read data, registered.
- `inbuf_fifo_rd_data_val`  out  1  one-cycle pulse qualifying `rd_data`.
- `inbuf_fifo_count`  out  ADDR_W+1  occupancy.
- `inbuf_fifo_ovf`  out  1  sticky overflow error (write while full).
- `inbuf_fifo_udf`  out  1  sticky underflow error (read while empty).

## Operation
- **Write accept:** `wr_acc = wr_rq & ~full`. On accept, `mem[wr_ptr] <= wr_data` and `wr_ptr++`.
- **Read accept:** `rd_acc = rd_rq & mem_en & ~empty`. On accept, `rd_data <= mem[rd_ptr]` and `rd_ptr++`.
- **Pointers:** `ADDR_W` bits wide; wrap naturally from DEPTH-1 to 0.
- **Count:** `count <= count + wr_acc - rd_acc`, range 0..DEPTH. Flags are decoded combinationally from `count`:
  - `empty = (count==0)`
  - `full = (count==DEPTH)`
  - `afull = (count>=AFULL_TH)`
- **Simultaneous read and write:**
  - Both accepted in the same cycle: count is unchanged.
  - Full: a write is rejected even if a read is accepted in the same cycle. Flags are evaluated on the pre-cycle count.
  - Empty: a read is rejected even if a write occurs in the same cycle. There is no fall-through; write data is readable from the next cycle.
- **Rejected requests:**
  - A rejected write (`wr_rq & full`) sets `ovf`. Data is dropped and state is unchanged.
  - A rejected read (`rd_rq & mem_en & empty`) sets `udf`. `rd_data_val` stays 0.
  - `rd_rq` with `mem_en=0` is ignored: no pop, no `udf`, `rd_data` holds.
- **Sticky errors:** `ovf` and `udf` clear only on `rst` or `flush`.
- **flush:** has priority over any write or read in the same cycle. It clears pointers, count, `rd_data_val`, `ovf` and `udf`. `rd_data` holds its value. Storage contents are not cleared.
- **Reset values:**
  - Status: `empty=1`, `full=0`, `afull=0`, `count=0`, `rd_data_val=0`, `ovf=0`, `udf=0`.
  - Data and pointers: `rd_data=0`, both pointers 0.
- **Reset mid-operation:** an asynchronous `rst` clears all state immediately. In-flight data is lost.
- **Storage:** the array is not reset. It is inferred as a simple dual-port RAM with a registered read.

## Timing
- **Read latency:** 1 cycle. If `rd_acc` is high in cycle N, `rd_data` and `rd_data_val=1` are presented in cycle N+1.
- **`rd_data_val`:** high for exactly one cycle per accepted read. Back-to-back reads give a continuous valid stream.
- **Write-to-empty deassert:** 1 cycle. A write accepted in cycle N gives `empty=0` in cycle N+1.
- **Flags** are combinational from the `count` register, so there is no added latency beyond the count update.
- **Throughput:** one write and one read per cycle, sustained.

## Test plan
- **Fill and drain:** after reset, write 0x1..0x10 (DEPTH=16), then pop 16 times with `mem_en=1`.
  - During fill: `afull` asserts at count 14; `full` asserts after the 16th write.
  - During drain: data returns as 0x1..0x10, each one cycle after its request; `empty` reasserts after the last pop.
- **Overflow and underflow:**
  - 17th write while full → word dropped, `ovf=1`, count stays 16.
  - Read while empty → `udf=1`, no `rd_data_val`.
  - `flush` → both errors clear.
- **Simultaneous read and write:**
  - At count 5, write and read together for 20 cycles → count stays 5; data order is preserved across pointer wrap.
  - At full, write and read together → read accepted, write rejected, count becomes 15, `ovf=1`.
- **mem_en gating:** count 3, `rd_rq=1` with `mem_en=0` for 4 cycles → no pop, `rd_data` unchanged, `udf=0`. Raising `mem_en` → the three words pop in order.
- **Write into empty with read:** empty FIFO, write 0xA5 and read in the same cycle → read rejected, `udf=1`. Next cycle read → 0xA5 valid one cycle later.
- **Reset and flush mid-stream:**
  - With count 8 and reads in flight, assert `rst` asynchronously mid-cycle → all outputs take their reset values immediately.
  - Repeat with `flush` → same state except `rd_data` holds.

Source files
------------

// File: rtl/inbuf_fifo.sv
// inbuf_fifo: input-buffer FIFO between the host/DMA loader and the
// input-buffer controller. Host pushes words; the controller pops one word
// per accepted request with a one-cycle registered read. Flags decode
// straight from the occupancy register; ovf/udf are sticky until rst/flush.
module inbuf_fifo #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int AFULL_TH = DEPTH - 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              host_inbuf_fifo_wr_rq,
  input  logic [DATA_W-1:0] host_inbuf_fifo_wr_data,
  output logic              inbuf_fifo_host_full,
  output logic              inbuf_fifo_host_afull,
  input  logic              cntl_inbuf_fifo_rd_rq,
  input  logic              cntl_inbuf_fifo_mem_en,
  output logic              inbuf_fifo_cntl_empty,
  output logic [DATA_W-1:0] inbuf_fifo_rd_data,
  output logic              inbuf_fifo_rd_data_val,
  output logic [ADDR_W:0]   inbuf_fifo_count,
  output logic              inbuf_fifo_ovf,
  output logic              inbuf_fifo_udf
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_TH);

  // Storage is deliberately left without reset so it maps onto block RAM.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [DATA_W-1:0] rd_data_reg;
  logic              rd_val_reg, rd_val_next;
  logic              ovf_reg, ovf_next;
  logic              udf_reg, udf_next;

  logic empty, full, afull;
  logic rd_req;
  logic wr_acc, rd_acc;

  // Flag decode from the registered count, request qualification, and next-state.
  // flush masks both accepts so it wins over any same-cycle traffic.
  always_comb begin
    empty  = (count_reg == '0);
    full   = (count_reg == DEPTH_C);
    afull  = (count_reg >= AFULL_C);
    rd_req = cntl_inbuf_fifo_rd_rq & cntl_inbuf_fifo_mem_en;
    wr_acc = ~flush & host_inbuf_fifo_wr_rq & ~full;
    rd_acc = ~flush & rd_req & ~empty;

    wr_ptr_next = wr_acc ? wr_ptr_reg + ADDR_W'(1) : wr_ptr_reg;
    rd_ptr_next = rd_acc ? rd_ptr_reg + ADDR_W'(1) : rd_ptr_reg;

    count_next = count_reg;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase

    rd_val_next = rd_acc;
    ovf_next    = ovf_reg | (host_inbuf_fifo_wr_rq & full);
    udf_next    = udf_reg | (rd_req & empty);

    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
      rd_val_next = 1'b0;
      ovf_next    = 1'b0;
      udf_next    = 1'b0;
    end
  end

  // RAM write port.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_reg] <= host_inbuf_fifo_wr_data;
    end
  end

  // Registered RAM read; holds its value when no read is accepted (including flush).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_reg <= '0;
    end else if (rd_acc) begin
      rd_data_reg <= mem[rd_ptr_reg];
    end
  end

  // Pointers, occupancy, valid pulse and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      rd_val_reg <= 1'b0;
      ovf_reg    <= 1'b0;
      udf_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      rd_val_reg <= rd_val_next;
      ovf_reg    <= ovf_next;
      udf_reg    <= udf_next;
    end
  end

  assign inbuf_fifo_host_full   = full;
  assign inbuf_fifo_host_afull  = afull;
  assign inbuf_fifo_cntl_empty  = empty;
  assign inbuf_fifo_rd_data     = rd_data_reg;
  assign inbuf_fifo_rd_data_val = rd_val_reg;
  assign inbuf_fifo_count       = count_reg;
  assign inbuf_fifo_ovf         = ovf_reg;
  assign inbuf_fifo_udf         = udf_reg;

endmodule

// File: tb/tb_inbuf_fifo.sv
// Self-checking bench for inbuf_fifo: a queue model of the FIFO contents
// decides acceptance, accepted reads push their expected word onto a
// scoreboard queue, and every valid beat from the DUT pops and compares.
module tb_inbuf_fifo;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              wr_rq;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic              afull;
  logic              rd_rq;
  logic              mem_en;
  logic              empty;
  logic [DATA_W-1:0] rd_data;
  logic              rd_val;
  logic [ADDR_W:0]   count;
  logic              ovf;
  logic              udf;

  inbuf_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .flush                   (flush),
    .host_inbuf_fifo_wr_rq   (wr_rq),
    .host_inbuf_fifo_wr_data (wr_data),
    .inbuf_fifo_host_full    (full),
    .inbuf_fifo_host_afull   (afull),
    .cntl_inbuf_fifo_rd_rq   (rd_rq),
    .cntl_inbuf_fifo_mem_en  (mem_en),
    .inbuf_fifo_cntl_empty   (empty),
    .inbuf_fifo_rd_data      (rd_data),
    .inbuf_fifo_rd_data_val  (rd_val),
    .inbuf_fifo_count        (count),
    .inbuf_fifo_ovf          (ovf),
    .inbuf_fifo_udf          (udf)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DATA_W-1:0] model_q[$];
  logic [DATA_W-1:0] exp_q[$];
  logic              m_ovf;
  logic              m_udf;
  logic [DATA_W-1:0] last_rd;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_q.delete();
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    last_rd = '0;
  endtask

  // Compare every output against the model; consume a scoreboard entry on a valid beat.
  task automatic check_all();
    logic [DATA_W-1:0] e;
    int n;
    n = model_q.size();
    check("count", 64'(count), 64'(n));
    check("empty", 64'(empty), 64'(n == 0));
    check("full",  64'(full),  64'(n == DEPTH));
    check("afull", 64'(afull), 64'(n >= DEPTH - 2));
    check("ovf",   64'(ovf),   64'(m_ovf));
    check("udf",   64'(udf),   64'(m_udf));
    check("rd_val", 64'(rd_val), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("rd_data", 64'(rd_data), 64'(e));
      last_rd = e;
      $display("rd  data=0x%08h expected=0x%08h count=%0d", rd_data, e, count);
    end else begin
      check("rd_hold", 64'(rd_data), 64'(last_rd));
    end
  endtask

  // One clock of stimulus; called and returning at posedge+1.
  task automatic step(input logic wr, input logic [DATA_W-1:0] d, input logic rd,
                      input logic en, input logic fl);
    int n;
    wr_rq   = wr;
    wr_data = d;
    rd_rq   = rd;
    mem_en  = en;
    flush   = fl;
    @(posedge clk);
    n = model_q.size();
    if (fl) begin
      model_q.delete();
      exp_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (wr && n == DEPTH) m_ovf = 1'b1;
      if (rd && en && n == 0) m_udf = 1'b1;
      if (rd && en && n != 0) exp_q.push_back(model_q.pop_front());
      if (wr && n != DEPTH) model_q.push_back(d);
    end
    #1;
    check_all();
    wr_rq  = 1'b0;
    rd_rq  = 1'b0;
    mem_en = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic wr(input logic [DATA_W-1:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd();
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_flush();
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; wr_rq = 1'b0; wr_data = '0;
    rd_rq = 1'b0; mem_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    check_all();

    // Fill and drain, with overflow on the 17th write and underflow when empty
    for (int i = 1; i <= DEPTH; i++) wr(DATA_W'(i));
    wr(32'h11);
    for (int i = 0; i < DEPTH; i++) rd();
    idle();
    rd();
    idle();
    do_flush();

    // Simultaneous read/write at count 5 across pointer wrap
    for (int i = 0; i < 5; i++) wr(32'h100 + DATA_W'(i));
    for (int i = 0; i < 20; i++) step(1'b1, 32'h200 + DATA_W'(i), 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) rd();
    idle();

    // Full with simultaneous read and write: read wins, write rejected
    for (int i = 0; i < DEPTH; i++) wr(32'h300 + DATA_W'(i));
    step(1'b1, 32'hDEAD, 1'b1, 1'b1, 1'b0);
    idle();
    do_flush();

    // mem_en gating
    for (int i = 0; i < 3; i++) wr(32'h400 + DATA_W'(i));
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) rd();
    idle();
    do_flush();

    // Write into empty with same-cycle read: no fall-through
    step(1'b1, 32'hA5, 1'b1, 1'b1, 1'b0);
    rd();
    idle();
    do_flush();

    // Asynchronous reset mid-cycle with a read in flight
    for (int i = 0; i < 9; i++) wr(32'h500 + DATA_W'(i));
    rd();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    check_all();

    // Flush mid-stream with a read in flight: rd_data holds
    for (int i = 0; i < 9; i++) wr(32'h600 + DATA_W'(i));
    rd();
    step(1'b0, '0, 1'b1, 1'b1, 1'b1);
    idle();
    rd();
    idle();
    do_flush();

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 40) == 0));
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
